// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the IFU/LSU memory-port arbiter.
// Owner values double as the bit index of each requester in the grant vector.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bundles: requester ports carry resp_err, the memory port does not.
// Handshake: a request transfers on a cycle where req_valid && req_ready; resp_valid is a one-cycle pulse that is always accepted.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_W-1:0]     req_addr;
  logic                  req_wen;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wmask;
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface mem_arbiter_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_W-1:0]     req_addr;
  logic                  req_wen;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wmask;
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone request wins; on a tie the side that is not i_last wins.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      o_gnt = i_last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU and LSU: one outstanding transaction,
// round-robin winner selection, response routing and a WAIT-state timeout.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_arbiter_if.slave        ifu,
  mem_arbiter_if.slave        lsu,
  mem_arbiter_mem_if.master   m,
  output logic                busy,
  output arb_state_t          o_dbg_state
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  arb_state_t            r_state;
  owner_t                r_owner;
  owner_t                r_last;
  logic [TW-1:0]         r_tcnt;
  logic [ADDR_W-1:0]     r_addr;
  logic                  r_wen;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W/8-1:0]   r_wmask;

  logic [1:0]            w_req;
  logic [1:0]            w_gnt;
  logic                  w_accept;
  logic                  w_fire;
  logic                  w_err;
  logic [DATA_W-1:0]     w_rdata;
  owner_t                w_win;

  assign w_req = {lsu.req_valid, ifu.req_valid};

  rr_arb2 u_rr (
    .i_req  (w_req),
    .i_last (r_last),
    .o_gnt  (w_gnt)
  );

  // rst_n in the accept term keeps ready low while reset is held, even with valid inputs.
  assign w_accept = rst_n && (r_state == ST_IDLE) && (w_gnt != 2'b00);
  assign w_win    = w_gnt[1] ? OWN_LSU : OWN_IFU;

  assign ifu.req_ready = w_accept && w_gnt[0];
  assign lsu.req_ready = w_accept && w_gnt[1];

  // A real response in the timeout cycle wins over the error.
  assign w_fire  = (r_state == ST_WAIT) && (m.resp_valid || (r_tcnt == TMAX));
  assign w_err   = !m.resp_valid;
  assign w_rdata = (m.resp_valid && !r_wen) ? m.resp_rdata : '0;

  assign ifu.resp_valid = w_fire && (r_owner == OWN_IFU);
  assign ifu.resp_rdata = ifu.resp_valid ? w_rdata : '0;
  assign ifu.resp_err   = ifu.resp_valid && w_err;
  assign lsu.resp_valid = w_fire && (r_owner == OWN_LSU);
  assign lsu.resp_rdata = lsu.resp_valid ? w_rdata : '0;
  assign lsu.resp_err   = lsu.resp_valid && w_err;

  assign m.req_valid = (r_state == ST_SEND);
  assign m.req_addr  = r_addr;
  assign m.req_wen   = r_wen;
  assign m.req_wdata = r_wdata;
  assign m.req_wmask = r_wmask;

  assign busy        = (r_state != ST_IDLE);
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_IFU;
      r_last  <= OWN_LSU;
      r_tcnt  <= '0;
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr  <= w_gnt[1] ? lsu.req_addr  : ifu.req_addr;
            r_wen   <= w_gnt[1] ? lsu.req_wen   : ifu.req_wen;
            r_wdata <= w_gnt[1] ? lsu.req_wdata : ifu.req_wdata;
            r_wmask <= w_gnt[1] ? lsu.req_wmask : ifu.req_wmask;
            r_owner <= w_win;
            r_last  <= w_win;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (m.req_ready) begin
            r_tcnt  <= '0;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_fire) begin
            r_state <= ST_IDLE;
          end else if (r_tcnt != TMAX) begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
